// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR front-end serializer.
package fir_pkg;

  localparam int DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

  // Bit-counter width for a burst of the given length; a 1-bit burst still needs a counter bit.
  function automatic int bit_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fir_word_buffer.sv
// One-deep holding register between the sample source and the serializer FSM.
module fir_word_buffer
  import fir_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Load and drain are mutually exclusive: load needs an empty slot, drain a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (load && !full) begin
      data <= load_data;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_word_serializer.sv
// Parallel-to-serial feeder: buffers one sample, then shifts it LSB first into the bit-serial FIR.
module fir_word_serializer #(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  input  logic                  i_fir_ready,
  output logic                  o_din,
  output logic                  o_din_valid,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_word_count
);

  import fir_pkg::*;

  localparam int BW = bit_cnt_width(DATA_WIDTH);

  ser_state_t            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic [BW-1:0]         bit_cnt;
  logic [7:0]            gap_cnt;
  logic                  start;

  assign start        = (state == IDLE) && buf_full && i_en && i_fir_ready;
  assign o_word_ready = ~buf_full;
  assign shreg_next   = shreg >> 1;
  // shreg is cleared by the time a burst ends; the gate keeps the line quiet after reset too.
  assign o_din        = o_din_valid & shreg[0];

  fir_word_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .load     (i_word_valid),
    .load_data(i_word),
    .drain    (start),
    .data     (buf_data),
    .full     (buf_full)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      o_din_valid  <= 1'b0;
      o_busy       <= 1'b0;
      o_word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= buf_data;
            bit_cnt     <= '0;
            o_din_valid <= 1'b1;
            o_busy      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg_next;
          bit_cnt <= bit_cnt + 1'b1;
          // A burst always runs to its last bit; i_en and i_fir_ready are not looked at here.
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            o_word_count <= o_word_count + 1'b1;
            o_din_valid  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_word_serializer.sv
// Scoreboard bench: dut0 has no gap and a 4-bit counter, dut1 has a 50-cycle gap.
module tb_fir_word_serializer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en         [2];
  logic [DW-1:0] word       [2];
  logic          word_valid [2];
  logic          word_ready [2];
  logic          fir_ready  [2];
  logic          din        [2];
  logic          din_valid  [2];
  logic          busy       [2];
  logic [3:0]    cnt0;
  logic [15:0]   cnt1;

  bit q0[$];
  bit q1[$];
  int errors = 0;
  int checks = 0;
  int last_idle [2];
  int bursts    [2];

  always #5 clk = ~clk;

  fir_word_serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(0), .CNT_WIDTH(4)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_en(en[0]), .i_word(word[0]),
    .i_word_valid(word_valid[0]), .o_word_ready(word_ready[0]),
    .i_fir_ready(fir_ready[0]), .o_din(din[0]), .o_din_valid(din_valid[0]),
    .o_busy(busy[0]), .o_word_count(cnt0)
  );

  fir_word_serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(50), .CNT_WIDTH(16)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_en(en[1]), .i_word(word[1]),
    .i_word_valid(word_valid[1]), .o_word_ready(word_ready[1]),
    .i_fir_ready(fir_ready[1]), .o_din(din[1]), .o_din_valid(din_valid[1]),
    .o_busy(busy[1]), .o_word_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit pop_exp(input int idx);
    if (idx == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic push_exp(input int idx, input logic [DW-1:0] w);
    for (int j = 0; j < DW; j++) begin
      if (idx == 0) q0.push_back(w[j]);
      else q1.push_back(w[j]);
    end
  endtask

  task automatic send(input int idx, input logic [DW-1:0] w);
    int n = 0;
    bit done = 0;
    word[idx]       = w;
    word_valid[idx] = 1'b1;
    while (!done && n < 200) begin
      if (word_ready[idx]) done = 1;
      tick();
      n++;
    end
    word_valid[idx] = 1'b0;
    if (done) begin
      push_exp(idx, w);
      $display("dut%0d accepted word %06h", idx, w);
    end
    check("send_accepted", {31'b0, done}, 1);
  endtask

  task automatic wait_valid(input int idx, input int budget);
    int n = 0;
    while (!din_valid[idx] && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", din_valid[idx], 1);
  endtask

  task automatic wait_drain(input int idx, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      done = word_ready[idx] && !busy[idx] && (qsize(idx) == 0);
      if (!done) begin
        tick();
        n++;
      end
    end
    check("drain_done", {31'b0, done}, 1);
  endtask

  // Pops one expected bit per valid cycle and checks burst length and idle-line behaviour.
  task automatic monitor(input int idx);
    int run = 0;
    int idle = 0;
    bit e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run  = 0;
        idle = 0;
      end else if (din_valid[idx]) begin
        if (run == 0) begin
          last_idle[idx] = idle;
          idle = 0;
        end
        run++;
        check("busy_in_burst", busy[idx], 1);
        if (qsize(idx) == 0) check("bit_unexpected", qsize(idx), 1);
        else begin
          e = pop_exp(idx);
          check("serial_bit", din[idx], e);
        end
      end else begin
        if (run != 0) begin
          check("burst_len", run, DW);
          bursts[idx]++;
          $display("dut%0d burst %0d done, %0d bits", idx, bursts[idx], run);
          run = 0;
        end
        idle++;
        check("din_idle_zero", din[idx], 0);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int g;
    logic [DW-1:0] w;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; fir_ready[i] = 1'b1; word_valid[i] = 1'b1; word[i] = 24'hDEAD01;
      last_idle[i] = 0; bursts[i] = 0;
    end
    repeat (5) tick();
    check("rst_din_valid", din_valid[0], 0);
    check("rst_count", cnt0, 0);
    check("rst_ready", word_ready[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_ready_dut1", word_ready[1], 1);
    word_valid[0] = 1'b0;
    word_valid[1] = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", word_ready[0], 1);
    tick();
    check("post_rst_no_burst", din_valid[0], 0);

    // dut1: gap after each burst, i_en dropped mid-burst
    send(1, 24'h0F0F0F);
    wait_valid(1, 10);
    repeat (5) tick();
    en[1] = 1'b0;
    send(1, 24'h00F00F);
    g = 0;
    while (din_valid[1] && g < 100) begin tick(); g++; end
    check("gap_busy", busy[1], 1);
    g = 0;
    while (busy[1] && g < 300) begin tick(); g++; end
    check("gap_len", g, 50);
    check("gap_count", cnt1, 1);
    bad = 0;
    repeat (20) begin tick(); if (din_valid[1]) bad++; end
    check("en_low_hold", bad, 0);
    check("en_low_buffer_kept", word_ready[1], 0);
    en[1] = 1'b1;
    wait_drain(1, 100);
    check("gap_idle_min", last_idle[1] >= 50, 1);
    check("gap_count2", cnt1, 2);

    // dut0: single word latency
    send(0, 24'hA5A5A5);
    check("lat_before", din_valid[0], 0);
    tick();
    check("lat_first_bit", din_valid[0], 1);
    wait_drain(0, 100);
    check("count_single", cnt0, 1);

    // back-to-back words
    send(0, 24'h000001);
    check("b2b_ready_low", word_ready[0], 0);
    send(0, 24'h800000);
    wait_drain(0, 150);
    check("b2b_idle_gap", last_idle[0], 1);
    check("count_b2b", cnt0, 3);

    // filter stall, then ready dropped mid-burst
    fir_ready[0] = 1'b0;
    send(0, 24'h3C5A96);
    bad = 0;
    repeat (40) begin tick(); if (din_valid[0] || word_ready[0]) bad++; end
    check("stall_quiet", bad, 0);
    fir_ready[0] = 1'b1;
    tick();
    check("stall_release_start", din_valid[0], 1);
    repeat (5) tick();
    fir_ready[0] = 1'b0;
    wait_drain(0, 100);
    check("count_stall", cnt0, 4);
    fir_ready[0] = 1'b1;

    // reset at bit 10 with a second word waiting in the buffer
    send(0, 24'hFFFFFF);
    send(0, 24'h123456);
    repeat (9) tick();
    check("pre_rst_bit", din[0], 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", din_valid[0], 0);
    check("rst_async_din", din[0], 0);
    check("rst_async_busy", busy[0], 0);
    check("rst_async_ready", word_ready[0], 1);
    check("rst_async_count", cnt0, 0);
    q0.delete();
    q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin tick(); if (din_valid[0]) bad++; end
    check("rst_buffer_discarded", bad, 0);
    check("rst_ready_after", word_ready[0], 1);

    // counter wrap: 2^4 + 1 bursts on the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      w = 24'($urandom);
      send(0, w);
    end
    wait_drain(0, 2000);
    check("count_wrap", cnt0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_word_serializer.md
Name: fir_word_serializer

Overview:
- Upstream feeder for the bit-serial FIR filter top level.
- Accepts parallel DATA_WIDTH-bit samples from a sample source (sine ROM, ADC capture) through a valid/ready handshake.
- Holds one sample in a 1-deep buffer, waits for the filter's ready, then shifts the sample out LSB first with a per-bit valid.
- Replaces hand-driven bit serialization in benches and system integration.

Parameters:
DATA_WIDTH, 24, sample width in bits; also the serial burst length.
GAP_CYCLES, 0, forced idle cycles after each burst before the next may start (0..255).
CNT_WIDTH, 16, width of the sent-word counter.

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  asynchronous, active-low reset
i_en  in  1  enable; sampled only at word boundaries
i_word  in  DATA_WIDTH  parallel sample
i_word_valid  in  1  i_word is valid
o_word_ready  out  1  buffer can accept a word
i_fir_ready  in  1  filter ready for a new serial word (filter o_ready)
o_din  out  1  serial data bit to filter i_din
o_din_valid  out  1  serial bit valid to filter i_din_valid
o_busy  out  1  burst or gap in progress
o_word_count  out  CNT_WIDTH  completed bursts, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (i_rst low, asynchronous): state=IDLE, buf_full=0, shift reg=0, bit counter=0, gap counter=0, o_din=0, o_din_valid=0, o_busy=0, o_word_count=0, o_word_ready=1 (equals ~buf_full).
- While i_rst is low, all inputs are ignored.
- Input handshake: a word is accepted on an edge with i_word_valid & o_word_ready. It is stored in buf and sets buf_full.
- o_word_ready = ~buf_full. There is no combinational path from i_fir_ready to o_word_ready.
- Mid-word i_word changes are ignored once the word is accepted.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: on an edge with buf_full & i_en & i_fir_ready:
  - shreg <= buf, buf_full <= 0, bitcnt <= 0, go to SHIFT.
  - Otherwise hold.
- SHIFT: o_din_valid=1, o_din=shreg[0], o_busy=1.
  - Each edge: shreg >>= 1, bitcnt++.
  - Exactly DATA_WIDTH valid cycles; bit j of the word appears in cycle j.
  - On the edge where bitcnt=DATA_WIDTH-1:
    - o_word_count++.
    - If GAP_CYCLES>0: go to GAP with gapcnt=0.
    - Else go to IDLE.
- GAP: o_din_valid=0, o_busy=1. gapcnt++ each edge; leave to IDLE after GAP_CYCLES cycles.
- Back-to-back bursts (GAP_CYCLES=0, buffer refilled during SHIFT, i_fir_ready high): the next burst's first bit follows one idle IDLE cycle. Bursts never merge.
- Latency: word accepted at edge k with IDLE, i_en=1, i_fir_ready=1 → o_din_valid high from edge k+1 to edge k+1+DATA_WIDTH.
- The buffer may be refilled while SHIFT or GAP is active. The new word never corrupts the word in flight.
- i_en low:
  - Blocks the IDLE→SHIFT transition only.
  - A burst in progress always completes all DATA_WIDTH bits, so the filter never sees a truncated word.
  - Input acceptance continues.
- i_fir_ready is sampled only in IDLE. Deassertion during SHIFT is ignored.
- Outside SHIFT: o_din=0.
- Reset asserted mid-burst: the burst is abandoned immediately, outputs go to reset values, and the buffered word is discarded.
- o_word_count wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Shared package fir_pkg:
  - DATA_WIDTH default (24).
  - ser_state_t enum {IDLE, SHIFT, GAP}.
  - Bit-counter width function $clog2(DATA_WIDTH).
- One natural sub-module: fir_word_buffer, a 1-deep valid/ready holding register with load/drain.
- FSM and shift register stay in the top.

Test Plan:
- Reset: hold i_rst=0 for 5 cycles, then drive i_word_valid=1 → o_din_valid=0, o_word_count=0, o_word_ready=1; no word accepted.
- Single word: i_word=24'hA5A5A5, i_fir_ready=1, i_en=1 → o_din_valid high exactly 24 cycles, starting 1 cycle after acceptance; serial stream 1,0,1,0,0,1,0,1 ×3 (LSB first); o_word_count=1.
- Back-to-back: words 24'h000001 then 24'h800000, second offered during the first burst → o_word_ready low until the first burst loads; bursts 1 idle cycle apart; second burst: 23 zeros then 1.
- Filter stall: i_fir_ready=0 for 40 cycles with buffer full → no o_din_valid, o_word_ready=0; i_fir_ready=1 → burst begins next edge. Dropping i_fir_ready mid-burst → still 24 bits.
- GAP_CYCLES=50 with i_en toggled low mid-burst → burst completes all 24 bits; ≥50 idle cycles; next burst only after i_en=1.
- Reset mid-burst: assert i_rst low at bit 10 of 24'hFFFFFF → o_din_valid=0 asynchronously; buffer empty after release; 2^16+1 bursts → o_word_count=1.
